// File: rtl/dtw_result_arbiter_if.sv
// Purpose: bundles the core request/result lines and the output-FIFO write port of the DTW result arbiter.
// Latency: none (wires only).
// Backpressure: dtw_fifo_full from the FIFO stalls the arbiter; cores hold core_req until core_ack pulses.
interface dtw_result_arbiter_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]    core_req;
    logic [32*NUM_CORES-1:0] core_score;
    logic [32*NUM_CORES-1:0] core_pos;
    logic [NUM_CORES-1:0]    core_ack;
    logic                    dtw_fifo_wren;
    logic [31:0]             dtw_fifo_din;
    logic                    dtw_fifo_full;

    // Arbiter side.
    modport master (
        input  core_req,
        input  core_score,
        input  core_pos,
        input  dtw_fifo_full,
        output core_ack,
        output dtw_fifo_wren,
        output dtw_fifo_din
    );

    // Cores + FIFO side.
    modport slave (
        output core_req,
        output core_score,
        output core_pos,
        output dtw_fifo_full,
        input  core_ack,
        input  dtw_fifo_wren,
        input  dtw_fifo_din
    );
endinterface

// File: rtl/dtw_result_arbiter.sv
// Purpose: round-robin share of the DTW output FIFO; each granted core result becomes a 3-word packet (header, score, pos).
// Latency: one grant cycle then three write cycles; back-to-back packets are separated by one IDLE cycle.
// Backpressure: dtw_fifo_full blocks the write and freezes state/data; no new grant while busy or while enable is low.
module dtw_result_arbiter #(
    parameter int          NUM_CORES     = 4,
    parameter int          BATCH_RESULTS = 8,
    parameter logic [7:0]  MAGIC         = 8'hD7
) (
    input  logic                   AXIS_ACLK,
    input  logic                   AXIS_ARESET,
    input  logic                   enable,
    dtw_result_arbiter_if.master   bus,
    output logic                   busy,
    output logic                   batch_done,
    output logic [15:0]            seq_num
);

    localparam int CW = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        SCORE = 2'd2,
        POS   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    // last_grant also serves as the captured core id: it only changes on a grant.
    logic [CW-1:0]        last_grant_q, last_grant_d;
    logic [31:0]          score_q, score_d;
    logic [31:0]          pos_q, pos_d;
    logic [15:0]          seq_q, seq_d;
    logic [15:0]          batch_cnt_q, batch_cnt_d;
    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic                 batch_done_q, batch_done_d;

    logic                 found;
    logic [CW-1:0]        win;
    logic [CW:0]          cand;
    logic                 wren;
    logic [31:0]          score_arr [NUM_CORES];
    logic [31:0]          pos_arr   [NUM_CORES];

    // Split the flat per-core result buses into per-core words.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            score_arr[i] = bus.core_score[32*i +: 32];
            pos_arr[i]   = bus.core_pos[32*i +: 32];
        end
    end

    // Round-robin search: first requester upward from last_grant+1, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = {1'b0, last_grant_q} + (CW+1)'(k);
            if (cand >= (CW+1)'(NUM_CORES)) begin
                cand = cand - (CW+1)'(NUM_CORES);
            end
            if (!found && bus.core_req[cand[CW-1:0]]) begin
                found = 1'b1;
                win   = cand[CW-1:0];
            end
        end
    end

    // Packet FSM: grant/capture in IDLE, advance one word per accepted FIFO write.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        score_d      = score_q;
        pos_d        = pos_q;
        seq_d        = seq_q;
        batch_cnt_d  = batch_cnt_q;
        ack_d        = '0;
        batch_done_d = 1'b0;
        wren         = (state_q != IDLE) && !bus.dtw_fifo_full;

        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    state_d      = HDR;
                    last_grant_d = win;
                    score_d      = score_arr[win];
                    pos_d        = pos_arr[win];
                    ack_d[win]   = 1'b1;
                end
            end
            HDR: begin
                if (wren) state_d = SCORE;
            end
            SCORE: begin
                if (wren) state_d = POS;
            end
            POS: begin
                if (wren) begin
                    state_d = IDLE;
                    seq_d   = seq_q + 16'd1;
                    if (batch_cnt_q == 16'(BATCH_RESULTS - 1)) begin
                        batch_cnt_d  = '0;
                        batch_done_d = 1'b1;
                    end else begin
                        batch_cnt_d  = batch_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output word mux; depends only on registered state so it holds while the FIFO is full.
    always_comb begin
        bus.dtw_fifo_din = '0;
        case (state_q)
            HDR:     bus.dtw_fifo_din = {MAGIC, 4'b0000, 4'(last_grant_q), seq_q};
            SCORE:   bus.dtw_fifo_din = score_q;
            POS:     bus.dtw_fifo_din = pos_q;
            default: bus.dtw_fifo_din = '0;
        endcase
    end

    // State and capture registers; reset abandons any partial packet.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q      <= IDLE;
            last_grant_q <= CW'(NUM_CORES - 1);
            score_q      <= '0;
            pos_q        <= '0;
            seq_q        <= '0;
            batch_cnt_q  <= '0;
            ack_q        <= '0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            score_q      <= score_d;
            pos_q        <= pos_d;
            seq_q        <= seq_d;
            batch_cnt_q  <= batch_cnt_d;
            ack_q        <= ack_d;
            batch_done_q <= batch_done_d;
        end
    end

    assign bus.dtw_fifo_wren = wren;
    assign bus.core_ack      = ack_q;
    assign busy              = (state_q != IDLE);
    assign batch_done        = batch_done_q;
    assign seq_num           = seq_q;

endmodule
